// File: rtl/sandbox_mem_reader_if.sv
// Bus bundle for sandbox_mem_reader: command port, memory read port and output stream.
// "master" is the reader side and "slave" is the surrounding environment.
interface sandbox_mem_reader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W:0]   cmd_len;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              done;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, mem_rd_data, out_ready,
    output cmd_ready, mem_rd_en, mem_rd_addr, out_valid, out_data, out_last, done
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, mem_rd_data, out_ready,
    input  cmd_ready, mem_rd_en, mem_rd_addr, out_valid, out_data, out_last, done
  );
endinterface

// File: rtl/sandbox_mem_reader.sv
// Burst reader: streams cmd_len words from a 1-cycle-latency RAM read port through a 2-entry buffer.
// Define SANDBOX_MEM_READER_WRAP_EN to wrap bursts past the top address instead of truncating them.
module sandbox_mem_reader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  sandbox_mem_reader_if.master  bus
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic              inflight, inflight_last;
  logic              ready_q, done_q, done_nxt;
  logic [DATA_W-1:0] ob_data [2];
  logic [1:0]        ob_last;
  logic [1:0]        count;
  logic [2:0]        credit;
  logic              accept, issue, rd_last, push, pop;

  assign accept = bus.cmd_valid & ready_q & (state == IDLE);
  assign pop    = (count != 2'd0) & bus.out_ready;
  assign push   = inflight;

  // A slot being popped this cycle counts as free, which keeps the pipe full at one word per cycle.
  assign credit = 3'd2 - {1'b0, count} + {2'b00, pop} - {2'b00, inflight};
  assign issue  = (state == READ) && (remaining != '0) && (credit != 3'd0);

`ifdef SANDBOX_MEM_READER_WRAP_EN
  assign rd_last = (remaining == (ADDR_W+1)'(1));
`else
  assign rd_last = (remaining == (ADDR_W+1)'(1)) || (addr == {ADDR_W{1'b1}});
`endif

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (accept && bus.cmd_len != '0) state_nxt = READ;
        if (accept && bus.cmd_len == '0) done_nxt = 1'b1;
      end
      READ: begin
        if (issue && rd_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (pop && ob_last[0]) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // cmd_ready is registered so it stays low for the whole time reset is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      addr          <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      ready_q       <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state         <= state_nxt;
      ready_q       <= (state_nxt == IDLE);
      done_q        <= done_nxt;
      inflight      <= issue;
      inflight_last <= issue & rd_last;
      if (accept) begin
        addr      <= bus.cmd_addr;
        remaining <= bus.cmd_len;
      end else if (issue) begin
        addr      <= addr + ADDR_W'(1);
        remaining <= rd_last ? '0 : remaining - (ADDR_W+1)'(1);
      end
    end
  end

  // Entry 0 is always the head, so the presented word only moves on a pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ob_data[0] <= '0;
      ob_data[1] <= '0;
      ob_last    <= 2'b00;
      count      <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            ob_data[0] <= bus.mem_rd_data;
            ob_last[0] <= inflight_last;
          end else begin
            ob_data[1] <= bus.mem_rd_data;
            ob_last[1] <= inflight_last;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          ob_data[0] <= ob_data[1];
          ob_last[0] <= ob_last[1];
          count      <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            ob_data[0] <= bus.mem_rd_data;
            ob_last[0] <= inflight_last;
          end else begin
            ob_data[0] <= ob_data[1];
            ob_last[0] <= ob_last[1];
            ob_data[1] <= bus.mem_rd_data;
            ob_last[1] <= inflight_last;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.cmd_ready   = ready_q;
  assign bus.mem_rd_en   = issue;
  assign bus.mem_rd_addr = addr;
  assign bus.out_valid   = (count != 2'd0);
  assign bus.out_data    = ob_data[0];
  assign bus.out_last    = (count != 2'd0) & ob_last[0];
  assign bus.done        = done_q;

endmodule

// File: doc/sandbox_mem_reader.md
SANDBOX_MEM_READER -- requirements
Module: sandbox_mem_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 16, memory word and stream width.
REQ-002 SHALL have parameter ADDR_W, default 8, memory address width; depth = 2^ADDR_W.
REQ-003 SHALL have ports:
- clk  input  1  single clock, all logic rising-edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  burst request.
- cmd_ready  output  1  reader accepts request.
- cmd_addr  input  ADDR_W  first word address.
- cmd_len  input  ADDR_W+1  word count, 0..2^ADDR_W.
- mem_rd_en  output  1  read strobe to the memory read port of the true dual-port RAM.
- mem_rd_addr  output  ADDR_W  read address.
- mem_rd_data  input  DATA_W  read data, valid exactly 1 cycle after mem_rd_en.
- out_valid  output  1  stream word valid.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  stream word.
- out_last  output  1  final word of burst.
- done  output  1  one-cycle pulse, burst finished.

Function
REQ-004 SHALL implement states IDLE, READ, DRAIN.
REQ-005 SHALL assert cmd_ready only in IDLE; a command transfers on cmd_valid & cmd_ready.
REQ-006 SHALL, on accepting cmd_len=0, stay in IDLE, issue no reads and pulse done the next cycle.
REQ-007 SHALL, on accepting cmd_len>0, latch address and remaining count and enter READ.
REQ-008 SHALL, in READ, assert mem_rd_en when remaining>0 and output buffer free slots minus in-flight reads >= 1; increment address and decrement remaining on each read.
REQ-009 SHALL contain a 2-entry output buffer; read data is captured into it on the cycle after mem_rd_en; no word is ever dropped or duplicated under any out_ready pattern.
REQ-010 SHALL present words on out_data in increasing address order, out_valid high whenever the buffer is non-empty, out_data/out_valid stable while out_valid & !out_ready.
REQ-011 SHALL assert out_last with exactly the final word of the burst.
REQ-012 SHALL move READ->DRAIN when remaining reaches 0, DRAIN->IDLE on the handshake of the out_last word, pulsing done in the following cycle.
REQ-013 SHALL sustain one word per cycle when out_ready is held high; first out_valid 2 cycles after command acceptance.
REQ-014 SHALL ignore cmd_valid outside IDLE.

Reset
REQ-015 SHALL, while reset is low, force state IDLE, buffer empty, and cmd_ready=0, mem_rd_en=0, mem_rd_addr=0, out_valid=0, out_data=0, out_last=0, done=0.
REQ-016 SHALL abandon any burst in progress on reset assertion; in-flight read data returning after release is discarded.
REQ-017 SHALL assert cmd_ready in the first cycle after reset release.

Configuration
REQ-018 SHALL use macro SANDBOX_MEM_READER_WRAP_EN.
REQ-019 SHALL, with SANDBOX_MEM_READER_WRAP_EN defined, wrap mem_rd_addr from 2^ADDR_W-1 to 0 and deliver all cmd_len words.
REQ-020 SHALL, without it, truncate a burst at address 2^ADDR_W-1: that word carries out_last, remaining words are not read, done pulses normally.

Verification
REQ-021 addr=0x10, len=4, out_ready=1 -> reads 0x10..0x13 on consecutive cycles, 4 words in order, out_last on word 4, done 1 cycle after its handshake.
REQ-022 len=8, out_ready toggled 1/0 each cycle -> 8 words, in order, no loss or duplicate, out_data stable while stalled.
REQ-023 len=0 -> no mem_rd_en, no out_valid, done pulse 1 cycle after acceptance.
REQ-024 addr=0xFE, len=4 -> with WRAP_EN: addresses FE,FF,00,01, last on 01; without: FE,FF only, last on FF.
REQ-025 reset low mid-burst after 3 of 6 words -> all outputs 0 immediately, cmd_ready=1 the cycle after release, new len=2 burst correct.
REQ-026 cmd_valid held during active burst -> ignored until IDLE, then accepted exactly once.
